rx_cfg_sequencer: RTL and testbench
===================================

Name: rx_cfg_sequencer

Overview:
- Owns the runtime configuration of the central receive DSP core: 5 phase increments (ddc, demix, duc1-3) and 4 LPF gains.
- Software writes land in shadow registers. A commit applies all phase increments atomically, then ramps the gains toward target, then holds a settle window while the filters flush.
- Outputs drive the DSP core config inputs directly. `out_valid` qualifies the DAC stream downstream.

Parameters:
- NUM_REGS, 9, shadow register count; addr 0-4 = ddc, demix, duc1, duc2, duc3 phase_inc; 5-8 = lpf1-lpf4 gain
- DATA_WIDTH, 16, width of every config word
- RAMP_STEP, 64, maximum gain change per clock
- SETTLE_CYCLES, 32, flush window after the ramp completes (>=1)

Ports:
- clock  in  1  single clock domain (fast DSP clock)
- resetn  in  1  asynchronous, active-low reset
- cfg_wr_en  in  1  shadow write strobe
- cfg_wr_addr  in  4  shadow register index
- cfg_wr_data  in  16  write data
- cfg_wr_err  out  1  one-cycle pulse when cfg_wr_en is high with addr >= NUM_REGS
- commit_req  in  1  request to apply the shadow registers
- commit_busy  out  1  high whenever the state is not IDLE
- commit_done  out  1  one-cycle pulse at the end of SETTLE
- out_valid  out  1  DAC data qualifier
- ddc_phase_inc, demix_phase_inc, duc1_phase_inc, duc2_phase_inc, duc3_phase_inc  out  16 each  live phase increments
- lpf1_gain, lpf2_gain, lpf3_gain, lpf4_gain  out  16 each  live gains, unsigned

Behaviour:
- Reset (asynchronous, resetn=0): shadow, target and live registers = 0; state IDLE; pending=0; out_valid=0; commit_busy, commit_done, cfg_wr_err = 0.
- Shadow writes:
  - Accepted in every state.
  - An out-of-range address leaves all shadow registers unchanged and pulses cfg_wr_err on the next cycle.
- FSM states: IDLE, APPLY, RAMP, SETTLE.
- IDLE:
  - commit_req=1 snapshots shadow into target at edge E0. A write in the same cycle is bypassed into the snapshot.
  - State -> APPLY; out_valid <= 0.
- APPLY (1 cycle): at E1 all 5 phase outputs <= target simultaneously; state -> RAMP.
- RAMP:
  - Every edge, each gain moves toward its target independently: g <= (|t-g| <= RAMP_STEP) ? t : g ± RAMP_STEP.
  - Arithmetic is unsigned 17-bit; no wrap past 0 or 0xFFFF.
  - On the edge where all four next-state gains equal target: state -> SETTLE; counter <= SETTLE_CYCLES-1.
  - Minimum RAMP duration is 1 cycle.
- SETTLE:
  - Counter decrements each edge.
  - At counter==0: commit_done pulses for 1 cycle.
  - pending=0: -> IDLE, out_valid <= 1.
  - pending=1: -> APPLY directly with a new snapshot (E0 semantics), pending <= 0, out_valid stays 0.
- commit_req while busy sets pending. Pending is one deep; further requests merge into it.
- A commit_req in the same cycle that SETTLE exits counts as pending.
- Zero-change commit latency: request sampled at E0, commit_done high in the cycle after edge E(2+SETTLE_CYCLES).
- Live outputs change only in APPLY (phase) and RAMP (gain). Writes during busy affect only shadow.
- Reset mid-commit: everything returns to reset values immediately; no done pulse.

Decomposition:
- Shared package rx_cfg_pkg holds:
  - the address localparams (ADDR_DDC_PHASE=0 ... ADDR_LPF4_GAIN=8);
  - the state enum typedef;
  - a packed struct rx_cfg_t with 5 phase and 4 gain fields, used for shadow, target and live.
- Sub-module gain_ramp_unit (one instance per gain): holds the current and target value, applies the step/clamp rule, and outputs at_target.

Test Plan:
- Reset then write addr0=0x1234, addr5=0x0100, commit -> ddc_phase_inc=0x1234 after E1. lpf1_gain steps 0x40, 0x80, 0xC0, 0x100 over 4 RAMP edges. commit_done 32 cycles after the ramp ends. out_valid rises with done.
- Lower lpf2_gain from 0x0100 to 0x0010 -> steps 0xC0, 0x80, 0x40, 0x10 (clamped, no underflow). Raise a gain from 0xFFC0 to 0xFFFF -> single step, no wrap.
- Write addr=9 -> cfg_wr_err pulse, shadow unchanged. Write addr1 and assert commit_req in the same cycle -> new value applied.
- commit_req twice during RAMP -> exactly one extra commit, 2 done pulses total. out_valid stays low across the back-to-back commits. Writes made during the first commit are applied by the second.
- Zero-change commit -> commit_done in the cycle after E34 (SETTLE_CYCLES=32). Phase and gain outputs unchanged.
- resetn low mid-RAMP -> all outputs 0 immediately, state IDLE, no done pulse. A commit after release works normally.

Source files
------------

// File: rtl/rx_cfg_pkg.sv
// Shared types for the receive-DSP configuration sequencer: register map,
// sequencer states and the packed configuration record.
package rx_cfg_pkg;

  localparam int NUM_REGS   = 9;
  localparam int DATA_WIDTH = 16;

  localparam logic [3:0] ADDR_DDC_PHASE   = 4'd0;
  localparam logic [3:0] ADDR_DEMIX_PHASE = 4'd1;
  localparam logic [3:0] ADDR_DUC1_PHASE  = 4'd2;
  localparam logic [3:0] ADDR_DUC2_PHASE  = 4'd3;
  localparam logic [3:0] ADDR_DUC3_PHASE  = 4'd4;
  localparam logic [3:0] ADDR_LPF1_GAIN   = 4'd5;
  localparam logic [3:0] ADDR_LPF2_GAIN   = 4'd6;
  localparam logic [3:0] ADDR_LPF3_GAIN   = 4'd7;
  localparam logic [3:0] ADDR_LPF4_GAIN   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_RAMP,
    ST_SETTLE
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] ddc_phase;
    logic [DATA_WIDTH-1:0] demix_phase;
    logic [DATA_WIDTH-1:0] duc1_phase;
    logic [DATA_WIDTH-1:0] duc2_phase;
    logic [DATA_WIDTH-1:0] duc3_phase;
    logic [DATA_WIDTH-1:0] lpf1_gain;
    logic [DATA_WIDTH-1:0] lpf2_gain;
    logic [DATA_WIDTH-1:0] lpf3_gain;
    logic [DATA_WIDTH-1:0] lpf4_gain;
  } rx_cfg_t;

  // Returns cfg with one field replaced; unknown addresses leave it intact.
  function automatic rx_cfg_t cfg_write(input rx_cfg_t cfg, input logic [3:0] addr,
                                        input logic [DATA_WIDTH-1:0] data);
    rx_cfg_t r;
    r = cfg;
    case (addr)
      ADDR_DDC_PHASE:   r.ddc_phase   = data;
      ADDR_DEMIX_PHASE: r.demix_phase = data;
      ADDR_DUC1_PHASE:  r.duc1_phase  = data;
      ADDR_DUC2_PHASE:  r.duc2_phase  = data;
      ADDR_DUC3_PHASE:  r.duc3_phase  = data;
      ADDR_LPF1_GAIN:   r.lpf1_gain   = data;
      ADDR_LPF2_GAIN:   r.lpf2_gain   = data;
      ADDR_LPF3_GAIN:   r.lpf3_gain   = data;
      ADDR_LPF4_GAIN:   r.lpf4_gain   = data;
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gain_ramp_unit.sv
// One live LPF gain: slews toward its target by at most RAMP_STEP per enabled
// clock, landing exactly on target without wrapping past 0 or full scale.
module gain_ramp_unit
  import rx_cfg_pkg::*;
#(
  parameter int RAMP_STEP = 64
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  step_en,
  input  logic [DATA_WIDTH-1:0] target,
  output logic [DATA_WIDTH-1:0] gain,
  output logic                  at_target
);

  localparam logic [DATA_WIDTH:0] STEP = (DATA_WIDTH+1)'(RAMP_STEP);

  logic [DATA_WIDTH:0]   cur_ext;
  logic [DATA_WIDTH:0]   tgt_ext;
  logic [DATA_WIDTH-1:0] gain_next;

  // One extra bit keeps the distance compare free of wrap-around.
  always_comb begin
    cur_ext = {1'b0, gain};
    tgt_ext = {1'b0, target};
    if (tgt_ext >= cur_ext) begin
      gain_next = (tgt_ext - cur_ext <= STEP) ? target : DATA_WIDTH'(cur_ext + STEP);
    end else begin
      gain_next = (cur_ext - tgt_ext <= STEP) ? target : DATA_WIDTH'(cur_ext - STEP);
    end
    at_target = (gain_next == target);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      gain <= '0;
    end else if (step_en) begin
      gain <= gain_next;
    end
  end

endmodule

// File: rtl/rx_cfg_sequencer.sv
// Runtime configuration owner for the receive DSP core: shadow writes,
// atomic phase-increment commit, gain ramp and filter-flush settle window.
module rx_cfg_sequencer
  import rx_cfg_pkg::*;
#(
  parameter int RAMP_STEP     = 64,
  parameter int SETTLE_CYCLES = 32
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        cfg_wr_en,
  input  logic [3:0]  cfg_wr_addr,
  input  logic [15:0] cfg_wr_data,
  output logic        cfg_wr_err,
  input  logic        commit_req,
  output logic        commit_busy,
  output logic        commit_done,
  output logic        out_valid,
  output logic [15:0] ddc_phase_inc,
  output logic [15:0] demix_phase_inc,
  output logic [15:0] duc1_phase_inc,
  output logic [15:0] duc2_phase_inc,
  output logic [15:0] duc3_phase_inc,
  output logic [15:0] lpf1_gain,
  output logic [15:0] lpf2_gain,
  output logic [15:0] lpf3_gain,
  output logic [15:0] lpf4_gain
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t  state_q, state_d;
  rx_cfg_t shadow_q, shadow_d, target_q, live;

  logic [4:0][DATA_WIDTH-1:0] phase_q;
  logic [3:0][DATA_WIDTH-1:0] gain_live;
  logic [3:0][DATA_WIDTH-1:0] gain_target;
  logic [3:0]                 gain_at_target;
  logic [CW-1:0]              cnt_q;

  logic wr_ok, wr_bad;
  logic pending_q, pending_d;
  logic valid_d, done_d;
  logic snap, apply, ramp_en, load_cnt, dec_cnt;

  always_comb begin
    wr_ok    = cfg_wr_en && (cfg_wr_addr <  4'(NUM_REGS));
    wr_bad   = cfg_wr_en && (cfg_wr_addr >= 4'(NUM_REGS));
    // Snapshots read shadow_d so a write in the commit cycle is included.
    shadow_d = wr_ok ? cfg_write(shadow_q, cfg_wr_addr, cfg_wr_data) : shadow_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d   = state_q;
    pending_d = pending_q;
    valid_d   = out_valid;
    done_d    = 1'b0;
    snap      = 1'b0;
    apply     = 1'b0;
    ramp_en   = 1'b0;
    load_cnt  = 1'b0;
    dec_cnt   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit_req) begin
          snap    = 1'b1;
          valid_d = 1'b0;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        apply   = 1'b1;
        state_d = ST_RAMP;
        if (commit_req) pending_d = 1'b1;
      end
      ST_RAMP: begin
        ramp_en = 1'b1;
        if (commit_req) pending_d = 1'b1;
        if (&gain_at_target) begin
          load_cnt = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
          // A request arriving on the exit cycle is treated like a pending one.
          if (pending_q || commit_req) begin
            snap      = 1'b1;
            pending_d = 1'b0;
            state_d   = ST_APPLY;
          end else begin
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          dec_cnt = 1'b1;
          if (commit_req) pending_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: shadow and target are plain flops rather than a RAM, so they take the async reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shadow_q    <= '0;
      target_q    <= '0;
      phase_q     <= '0;
      pending_q   <= 1'b0;
      out_valid   <= 1'b0;
      commit_done <= 1'b0;
      cfg_wr_err  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking throughout so every flop samples pre-edge values.
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      out_valid   <= valid_d;
      commit_done <= done_d;
      cfg_wr_err  <= wr_bad;
      if (snap) target_q <= shadow_d;
      if (apply) begin
        phase_q[0] <= target_q.ddc_phase;
        phase_q[1] <= target_q.demix_phase;
        phase_q[2] <= target_q.duc1_phase;
        phase_q[3] <= target_q.duc2_phase;
        phase_q[4] <= target_q.duc3_phase;
      end
      if (load_cnt)     cnt_q <= CW'(SETTLE_CYCLES - 1);
      else if (dec_cnt) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign gain_target[0] = target_q.lpf1_gain;
  assign gain_target[1] = target_q.lpf2_gain;
  assign gain_target[2] = target_q.lpf3_gain;
  assign gain_target[3] = target_q.lpf4_gain;

  for (genvar g = 0; g < 4; g++) begin : g_gain
    gain_ramp_unit #(
      .RAMP_STEP(RAMP_STEP)
    ) u_ramp (
      .clock    (clock),
      .resetn   (resetn),
      .step_en  (ramp_en),
      .target   (gain_target[g]),
      .gain     (gain_live[g]),
      .at_target(gain_at_target[g])
    );
  end

  always_comb begin
    live.ddc_phase   = phase_q[0];
    live.demix_phase = phase_q[1];
    live.duc1_phase  = phase_q[2];
    live.duc2_phase  = phase_q[3];
    live.duc3_phase  = phase_q[4];
    live.lpf1_gain   = gain_live[0];
    live.lpf2_gain   = gain_live[1];
    live.lpf3_gain   = gain_live[2];
    live.lpf4_gain   = gain_live[3];
  end

  assign commit_busy     = (state_q != ST_IDLE);
  assign ddc_phase_inc   = live.ddc_phase;
  assign demix_phase_inc = live.demix_phase;
  assign duc1_phase_inc  = live.duc1_phase;
  assign duc2_phase_inc  = live.duc2_phase;
  assign duc3_phase_inc  = live.duc3_phase;
  assign lpf1_gain       = live.lpf1_gain;
  assign lpf2_gain       = live.lpf2_gain;
  assign lpf3_gain       = live.lpf3_gain;
  assign lpf4_gain       = live.lpf4_gain;

endmodule

// File: tb/tb_rx_cfg_sequencer.sv
// Bench for rx_cfg_sequencer: directed scenarios plus random traffic, checked
// every cycle against a commit-schedule model (closed-form ramp timing).
module tb_rx_cfg_sequencer;

  localparam int STEP   = 64;
  localparam int SETTLE = 32;

  logic        clock;
  logic        resetn;
  logic        cfg_wr_en;
  logic [3:0]  cfg_wr_addr;
  logic [15:0] cfg_wr_data;
  logic        cfg_wr_err;
  logic        commit_req;
  logic        commit_busy;
  logic        commit_done;
  logic        out_valid;
  logic [15:0] ddc_phase_inc, demix_phase_inc, duc1_phase_inc, duc2_phase_inc, duc3_phase_inc;
  logic [15:0] lpf1_gain, lpf2_gain, lpf3_gain, lpf4_gain;

  rx_cfg_sequencer #(
    .RAMP_STEP    (STEP),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clock          (clock),
    .resetn         (resetn),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_wr_addr    (cfg_wr_addr),
    .cfg_wr_data    (cfg_wr_data),
    .cfg_wr_err     (cfg_wr_err),
    .commit_req     (commit_req),
    .commit_busy    (commit_busy),
    .commit_done    (commit_done),
    .out_valid      (out_valid),
    .ddc_phase_inc  (ddc_phase_inc),
    .demix_phase_inc(demix_phase_inc),
    .duc1_phase_inc (duc1_phase_inc),
    .duc2_phase_inc (duc2_phase_inc),
    .duc3_phase_inc (duc3_phase_inc),
    .lpf1_gain      (lpf1_gain),
    .lpf2_gain      (lpf2_gain),
    .lpf3_gain      (lpf3_gain),
    .lpf4_gain      (lpf4_gain)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  task automatic check(input string tag, input logic [143:0] act, input logic [143:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: a commit started at edge s applies phases at s+1, gains follow a
  // closed-form slew over L edges from s+2, done is seen after edge s+1+L+SETTLE.
  logic [15:0] m_shadow[9];
  logic [15:0] m_tgt[9];
  logic [15:0] m_old_phase[5];
  logic [15:0] m_g0[4];
  int          m_n, m_start, m_end;
  bit          m_busy, m_pend, m_valid, m_done, m_err;

  function automatic logic [15:0] exp_phase(input int i);
    return (m_n >= m_start + 1) ? m_tgt[i] : m_old_phase[i];
  endfunction

  function automatic logic [15:0] exp_gain(input int j);
    int g0, t, d, ad, k;
    g0 = int'(m_g0[j]);
    t  = int'(m_tgt[5+j]);
    d  = t - g0;
    ad = (d < 0) ? -d : d;
    k  = m_n - m_start - 1;
    if (k <= 0) return m_g0[j];
    if (ad <= k * STEP) return m_tgt[5+j];
    return 16'((d > 0) ? g0 + k * STEP : g0 - k * STEP);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      m_shadow[i] = '0;
      m_tgt[i]    = '0;
    end
    for (int i = 0; i < 5; i++) m_old_phase[i] = '0;
    for (int i = 0; i < 4; i++) m_g0[i] = '0;
    m_start = -100000;
    m_end   = 0;
    m_busy  = 0;
    m_pend  = 0;
    m_valid = 0;
    m_done  = 0;
    m_err   = 0;
  endtask

  task automatic model_edge(input bit en, input logic [3:0] addr, input logic [15:0] data,
                            input bit req);
    logic [15:0] s_new[9];
    bit start;
    int ramp_len, ad;
    m_n++;
    m_err = en && (addr >= 4'd9);
    for (int i = 0; i < 9; i++) s_new[i] = m_shadow[i];
    if (en && addr < 4'd9) s_new[addr] = data;
    m_done = 0;
    start  = 0;
    if (m_busy) begin
      if (m_n == m_end) begin
        m_done = 1;
        if (m_pend || req) begin
          start  = 1;
          m_pend = 0;
        end else begin
          m_busy  = 0;
          m_valid = 1;
        end
      end else if (req) begin
        m_pend = 1;
      end
    end else if (req) begin
      start   = 1;
      m_valid = 0;
    end
    if (start) begin
      for (int i = 0; i < 5; i++) m_old_phase[i] = exp_phase(i);
      for (int j = 0; j < 4; j++) m_g0[j] = exp_gain(j);
      for (int i = 0; i < 9; i++) m_tgt[i] = s_new[i];
      ramp_len = 1;
      for (int j = 0; j < 4; j++) begin
        ad = int'(m_tgt[5+j]) - int'(m_g0[j]);
        if (ad < 0) ad = -ad;
        if ((ad + STEP - 1) / STEP > ramp_len) ramp_len = (ad + STEP - 1) / STEP;
      end
      m_start = m_n;
      m_end   = m_n + 1 + ramp_len + SETTLE;
      m_busy  = 1;
    end
    for (int i = 0; i < 9; i++) m_shadow[i] = s_new[i];
  endtask

  task automatic compare_all();
    check("phase", {ddc_phase_inc, demix_phase_inc, duc1_phase_inc, duc2_phase_inc, duc3_phase_inc},
          {exp_phase(0), exp_phase(1), exp_phase(2), exp_phase(3), exp_phase(4)});
    check("gain", {lpf1_gain, lpf2_gain, lpf3_gain, lpf4_gain},
          {exp_gain(0), exp_gain(1), exp_gain(2), exp_gain(3)});
    check("busy", commit_busy, m_busy);
    check("done", commit_done, m_done);
    check("valid", out_valid, m_valid);
    check("wr_err", cfg_wr_err, m_err);
  endtask

  task automatic step(input bit en, input logic [3:0] addr, input logic [15:0] data, input bit req);
    cfg_wr_en   = en;
    cfg_wr_addr = addr;
    cfg_wr_data = data;
    commit_req  = req;
    @(posedge clock);
    model_edge(en, addr, data, req);
    #1;
    compare_all();
    if (commit_done === 1'b1) done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, 16'h0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && commit_busy === 1'b1; i++) step(0, 4'd0, 16'h0, 0);
    check("drain", commit_busy, 1'b0);
  endtask

  function automatic logic [15:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return 16'hFFFF - 16'($urandom_range(0, 150));
      2:       return 16'($urandom_range(0, 150));
      default: return 16'h8000 + 16'($urandom_range(0, 400));
    endcase
  endfunction

  int e0;

  initial begin
    resetn      = 1'b0;
    cfg_wr_en   = 1'b0;
    cfg_wr_addr = '0;
    cfg_wr_data = '0;
    commit_req  = 1'b0;
    m_n         = 0;
    model_reset();
    #12;
    compare_all();
    resetn = 1'b1;

    // Basic commit: phase apply, 4-step gain ramp, settle, valid with done.
    step(1, 4'd0, 16'h1234, 0);
    step(1, 4'd5, 16'h0100, 0);
    step(0, 4'd0, 16'h0, 1);
    drain();

    // Downward ramp with clamp, then upward to full scale without wrap.
    step(1, 4'd6, 16'h0100, 1);
    drain();
    step(1, 4'd6, 16'h0010, 1);
    drain();
    step(1, 4'd7, 16'hFFC0, 1);
    drain();
    step(1, 4'd7, 16'hFFFF, 1);
    drain();

    // Out-of-range writes, then a write bypassed into the commit snapshot.
    step(1, 4'd9, 16'hDEAD, 0);
    step(1, 4'hF, 16'hBEEF, 0);
    step(1, 4'd1, 16'hABCD, 1);
    drain();

    // Two requests during RAMP merge into one extra commit.
    step(1, 4'd8, 16'h0400, 0);
    done_seen = 0;
    step(0, 4'd0, 16'h0, 1);
    idle(2);
    step(1, 4'd2, 16'h5555, 1);
    idle(1);
    step(0, 4'd0, 16'h0, 1);
    drain();
    check("b2b_done_count", done_seen, 2);

    // Zero-change commit latency.
    step(0, 4'd0, 16'h0, 1);
    e0 = m_n;
    for (int i = 0; i < 100 && commit_done !== 1'b1; i++) step(0, 4'd0, 16'h0, 0);
    check("zero_latency", m_n - e0, 34);
    drain();

    // Asynchronous reset in the middle of a ramp, then a normal commit.
    step(1, 4'd5, 16'h1000, 1);
    idle(6);
    resetn = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2;
    resetn = 1'b1;
    idle(3);
    step(1, 4'd3, 16'h0F0F, 0);
    step(1, 4'd8, 16'h00C8, 1);
    drain();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 9) < 3), 4'($urandom_range(0, 11)), rand_data(),
           ($urandom_range(0, 29) == 0));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
